seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the datapath's single-cycle ALU. It keeps the seven single-cycle operations and adds iterative unsigned multiply, multiply-high, divide and remainder. It sits between the register-read stage and writeback of the multi-cycle CPU. The controller issues an operation with `start`, watches `busy`, and captures `res` when `done` pulses.

## Interface
- `WIDTH`, 32: operand and result width, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; not overridden).

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: issue request; sampled only when `busy`=0.
- `SrcA` input WIDTH: operand A / multiplicand / dividend.
- `SrcB` input WIDTH: operand B / multiplier / divisor.
- `control` input 4: operation select.
- `busy` output 1: high while an iterative operation runs.
- `done` output 1: one-cycle pulse; `res` is valid from this cycle on.
- `res` output WIDTH: registered result, held until the next completion.
- `zero` output 1: `~|res`.
- `sign` output 1: `res[WIDTH-1]`.

## Operation
- Opcodes:
  - 0000 add (signed, wraps).
  - 0001 sub (wraps).
  - 0010 and.
  - 0011 or.
  - 0100 xor.
  - 0101 slt (signed; yields 1/0).
  - 0110 sltu (yields 1/0).
  - 1000 mul: low WIDTH bits of the 2·WIDTH product.
  - 1001 mulhu: high WIDTH bits of the unsigned product.
  - 1010 divu: unsigned quotient.
  - 1011 remu: unsigned remainder.
  - 0111 and 11xx: result 0.
- Single-cycle class: 0000–0111, 11xx, and 1010/1011 with `SrcB`=0.
- Iterative class: 1000, 1001, and 1010/1011 with `SrcB`≠0.
- Divide by zero:
  - divu returns all ones.
  - remu returns `SrcA`.
  - Both complete on the single-cycle path.
- Multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle, on a WIDTH+1-bit partial remainder.
- Operands and opcode are latched at accept. Input changes during `busy` have no effect.
- FSM states and transitions:
  - IDLE: on `start`, a single-cycle op writes `res` and pulses `done`, and the FSM stays in IDLE. An iterative op loads the operand registers, sets counter=WIDTH, and moves to RUN.
  - RUN: performs one step per cycle and decrements the counter. When the counter reaches 1, the final step writes `res`, pulses `done`, and the FSM returns to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- `zero`/`sign` are derived combinationally from registered `res`, so they change only on completion.

## Timing
- Reset state (async assert, synchronous-safe deassert):
  - FSM: IDLE.
  - `res` = 0, `done` = 0, `busy` = 0.
  - Therefore `zero` = 1 and `sign` = 0.
- Single-cycle latency:
  - `start` sampled at edge k.
  - `res`/`done` are valid after edge k.
  - `busy` never rises.
- Iterative latency:
  - Accept at edge k; `busy` is high after edges k through k+WIDTH−1.
  - The final step happens at edge k+WIDTH.
  - After edge k+WIDTH: `busy`=0, `done`=1, `res` updated.
  - Total: WIDTH+1 cycles from the `start` cycle to the `done` cycle.
- `done` is high for exactly one cycle per accepted operation.
- `res` is stable from `done` until the next completion.
- Reset mid-RUN: the operation is aborted and no `done` is produced. `res` returns to 0.

## Test plan
- Reset, then sequential checks, WIDTH=32:
  - After reset, expect `res`=0, `zero`=1, `sign`=0, `busy`=0.
  - add 0x7FFFFFFF+1 → `res`=0x80000000, `sign`=1, `done` one cycle after `start`.
- Each single-cycle op, WIDTH=32:
  - sub 5−5 → 0, `zero`=1.
  - slt −1 vs 1 → 1.
  - sltu 0xFFFFFFFF vs 1 → 0.
  - opcode 0111 → 0.
- Iterative multiply, WIDTH=32:
  - mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - mulhu of the same operands → 0xFFFFFFFE.
  - `busy` high for exactly 32 cycles; `done` on cycle 33 after `start`.
- Iterative divide, WIDTH=32:
  - divu 100/7 → 14.
  - remu 100/7 → 2.
  - divu 7/0 → 0xFFFFFFFF with 1-cycle latency.
  - remu 7/0 → 7.
- Handshake:
  - Pulse `start` with altered inputs while `busy` → ignored; the original result completes.
  - `start` in the `done` cycle → back-to-back ops, both correct.
- Reset mid-operation, WIDTH=8 build:
  - Assert `rst_n`=0 during RUN of mulhu 0xFF×0xFF → no `done`, `res`=0.
  - After release, mulhu 0xFF×0xFF → 0xFE in 9 cycles.

Source files
------------

// File: rtl/seq_alu.sv
//------------------------------------------------------------------------------
// seq_alu : multi-cycle ALU with iterative unsigned multiply and divide
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             sign
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   // Shared accumulator: {hi, lo} = {partial product, multiplier} or {remainder, quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [1:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   fast_res;
   logic               iter_op;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] step_acc;

   always_comb begin
      fast_res = '0;
      case (control)
         4'b0000: fast_res = SrcA + SrcB;
         4'b0001: fast_res = SrcA - SrcB;
         4'b0010: fast_res = SrcA & SrcB;
         4'b0011: fast_res = SrcA | SrcB;
         4'b0100: fast_res = SrcA ^ SrcB;
         4'b0101: fast_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         4'b0110: fast_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         4'b1010: fast_res = '1;
         4'b1011: fast_res = SrcA;
         default: fast_res = '0;
      endcase
   end

   assign iter_op = (control == 4'b1000) || (control == 4'b1001) ||
                    ((control[3:1] == 3'b101) && (SrcB != '0));

   // One multiply step adds the multiplicand when the current multiplier bit is set;
   // one divide step shifts in the next dividend bit and subtracts when it fits.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ge    = (div_shift >= {1'b0, opb_q});
      if (op_q[1]) begin
         step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (iter_op) begin
                  op_d    = control[1:0];
                  opb_d   = control[1] ? SrcB : SrcA;
                  acc_d   = {{WIDTH{1'b0}}, (control[1] ? SrcA : SrcB)};
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = S_RUN;
               end else begin
                  res_d  = fast_res;
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               // mulhu/remu live in the high half, mul/divu in the low half
               res_d   = op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign res  = res_q;
   assign zero = ~|res_q;
   assign sign = res_q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//------------------------------------------------------------------------------
// tb_seq_alu : vector table, random ops against an arithmetic model, handshake
// and reset-abort sequences for seq_alu.
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [31:0] a, b;
   logic [3:0]  ctrl;
   logic        busy, done, zero, sign;
   logic [31:0] res;

   logic        rst8_n, start8;
   logic [7:0]  a8, b8;
   logic [3:0]  ctrl8;
   logic        busy8, done8, zero8, sign8;
   logic [7:0]  res8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .SrcA(a), .SrcB(b), .control(ctrl),
      .busy(busy), .done(done), .res(res), .zero(zero), .sign(sign)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst8_n), .start(start8), .SrcA(a8), .SrcB(b8), .control(ctrl8),
      .busy(busy8), .done(done8), .res(res8), .zero(zero8), .sign(sign8)
   );

   typedef struct {
      logic [3:0]  c;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] e;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      logic [31:0] r;
      p = {32'd0, x} * {32'd0, y};
      case (c)
         4'd0:    r = x + y;
         4'd1:    r = x - y;
         4'd2:    r = x & y;
         4'd3:    r = x | y;
         4'd4:    r = x ^ y;
         4'd5:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6:    r = (x < y) ? 32'd1 : 32'd0;
         4'd8:    r = p[31:0];
         4'd9:    r = p[63:32];
         4'd10:   r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'd11:   r = (y == 0) ? x : x % y;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [3:0] c, input logic [31:0] y);
      int l;
      l = 1;
      if (c == 4'd8 || c == 4'd9 || ((c == 4'd10 || c == 4'd11) && y != 0)) l = 33;
      return l;
   endfunction

   // Drives start for one edge from the current point, then waits for done.
   task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int cyc, output int bcyc);
      start = 1'b1; ctrl = c; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      bcyc  = 0;
      while (!done && cyc < 100) begin
         if (busy) bcyc++;
         @(posedge clk); #1;
         cyc++;
      end
      r = res;
   endtask

   task automatic check_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] e, input int lat);
      logic [31:0] r;
      int cyc, bcyc;
      issue(c, x, y, r, cyc, bcyc);
      chk({tag, "_res"},  r, e);
      chk({tag, "_lat"},  cyc, lat);
      chk({tag, "_busy"}, bcyc, lat - 1);
      chk({tag, "_zero"}, zero, (e == 0));
      chk({tag, "_sign"}, sign, e[31]);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[18];
      logic [31:0] r, x, y;
      logic [3:0]  c;
      int          cyc, bcyc;
      logic        saw_done;

      vecs[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1};
      vecs[1]  = '{4'b0001, 32'd5,         32'd5,         32'h0,         1};
      vecs[2]  = '{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1};
      vecs[3]  = '{4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1};
      vecs[4]  = '{4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1};
      vecs[5]  = '{4'b0101, 32'hFFFF_FFFF, 32'h1,         32'h1,         1};
      vecs[6]  = '{4'b0110, 32'hFFFF_FFFF, 32'h1,         32'h0,         1};
      vecs[7]  = '{4'b0111, 32'd5,         32'd3,         32'h0,         1};
      vecs[8]  = '{4'b1100, 32'd1,         32'd2,         32'h0,         1};
      vecs[9]  = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33};
      vecs[10] = '{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[11] = '{4'b1010, 32'd100,       32'd7,         32'd14,        33};
      vecs[12] = '{4'b1011, 32'd100,       32'd7,         32'd2,         33};
      vecs[13] = '{4'b1010, 32'd7,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[14] = '{4'b1011, 32'd7,         32'd0,         32'd7,         1};
      vecs[15] = '{4'b1000, 32'h1234_5678, 32'h10,        32'h2345_6780, 33};
      vecs[16] = '{4'b1010, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
      vecs[17] = '{4'b1011, 32'd5,         32'd9,         32'd5,         33};

      rst_n = 1'b0; start = 1'b0; ctrl = '0; a = '0; b = '0;
      rst8_n = 1'b0; start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_res",  res,  32'h0);
      chk("reset_zero", zero, 1'b1);
      chk("reset_sign", sign, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; rst8_n = 1'b1;
      @(negedge clk);

      // Consecutive issues start in the done cycle, so this also covers back-to-back ops.
      for (int i = 0; i < 18; i++) begin
         check_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].x, vecs[i].y, vecs[i].e, vecs[i].lat);
      end

      @(posedge clk); #1;
      chk("done_pulse_width", done, 1'b0);
      chk("res_held", res, 32'h5);

      // Start pulse and operand changes during RUN must be ignored.
      @(negedge clk);
      start = 1'b1; ctrl = 4'b1001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc == 6) begin
            start = 1'b1; ctrl = 4'b0000; a = 32'd1; b = 32'd2;
         end else if (cyc == 7) begin
            start = 1'b0; a = 32'd3; b = 32'd4;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("ignore_res", res, 32'hFFFF_FFFE);
      chk("ignore_lat", cyc, 33);
      @(posedge clk); #1;
      chk("ignore_not_queued_done", done, 1'b0);
      chk("ignore_not_queued_busy", busy, 1'b0);
      chk("ignore_res_stable", res, 32'hFFFF_FFFE);

      for (int i = 0; i < 150; i++) begin
         c = 4'($urandom_range(0, 15));
         x = $urandom;
         if ($urandom_range(0, 7) == 0) y = 32'd0;
         else if ($urandom_range(0, 1) == 1) y = $urandom;
         else y = 32'($urandom_range(1, 300));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         check_op($sformatf("rnd%0d_op%0d", i, c), c, x, y, model(c, x, y), model_lat(c, y));
      end

      // Reset abort on the 8-bit instance.
      @(negedge clk);
      start8 = 1'b1; ctrl8 = 4'b1001; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("w8_busy_before_abort", busy8, 1'b1);
      @(negedge clk);
      rst8_n = 1'b0;
      #1;
      chk("w8_abort_res",  res8,  8'h00);
      chk("w8_abort_busy", busy8, 1'b0);
      saw_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst8_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done8) saw_done = 1'b1;
      end
      chk("w8_abort_no_done", saw_done, 1'b0);
      chk("w8_abort_res_after", res8, 8'h00);
      chk("w8_abort_zero", zero8, 1'b1);

      @(negedge clk);
      start8 = 1'b1; ctrl8 = 4'b1001; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("w8_mulhu_res",  res8,  8'hFE);
      chk("w8_mulhu_lat",  cyc,   9);
      chk("w8_mulhu_sign", sign8, 1'b1);
      chk("w8_mulhu_zero", zero8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
